// File: rtl/star_raster_scanner_if.sv
// Bundle of the scanner's handshake and frame-memory signals.
//   start      : level request to begin a scan (driven by master FSM)
//   next_star  : one-cycle pulse releasing the current hit
//   mem_addr   : frame-memory read address, y*160 + x
//   mem_data   : frame-memory read data, one clock after mem_addr
//   star_x/y   : coordinate of the held hit
//   star_found : high while a hit is held
//   scan_done  : high once the whole frame has been scanned
// master = controller/memory side, slave = scanner side.
interface star_raster_scanner_if #(
  parameter int XSZ    = 8,
  parameter int YSZ    = 7,
  parameter int COLSZ  = 3,
  parameter int ADDRSZ = 15
) ();
  logic              start;
  logic              next_star;
  logic [ADDRSZ-1:0] mem_addr;
  logic [COLSZ-1:0]  mem_data;
  logic [XSZ-1:0]    star_x;
  logic [YSZ-1:0]    star_y;
  logic              star_found;
  logic              scan_done;

  modport master (
    output start, next_star, mem_data,
    input  mem_addr, star_x, star_y, star_found, scan_done
  );

  modport slave (
    input  start, next_star, mem_data,
    output mem_addr, star_x, star_y, star_found, scan_done
  );
endinterface

// File: rtl/star_raster_scanner.sv
// Raster scanner feeding the star finder. Walks the 160x120 frame one pixel
// per clock, stops on the first pixel whose colour equals STAR_COL and holds
// its coordinate until next_star, then resumes from the following pixel.
// Ports:
//   clk    : system clock, rising edge
//   resetn : synchronous active-low reset
//   sif    : slave side of star_raster_scanner_if (start, next_star,
//            mem_addr, mem_data, star_x, star_y, star_found, scan_done)
module star_raster_scanner #(
  parameter int               XSZ      = 8,
  parameter int               YSZ      = 7,
  parameter int               COLSZ    = 3,
  parameter int               ADDRSZ   = 15,
  parameter int               X_MAX    = 160,
  parameter int               Y_MAX    = 120,
  parameter logic [COLSZ-1:0] STAR_COL = 3'b111
) (
  input logic                   clk,
  input logic                   resetn,
  star_raster_scanner_if.slave  sif
);

  typedef enum logic [1:0] {IDLE, SCAN, FOUND, DONE} state_t;

  localparam logic [XSZ-1:0] X_LAST = XSZ'(X_MAX - 1);
  localparam logic [YSZ-1:0] Y_LAST = YSZ'(Y_MAX - 1);

  // y*160 built from shifts: 160 = 128 + 32
  function automatic logic [ADDRSZ-1:0] pix_addr(input logic [XSZ-1:0] x,
                                                 input logic [YSZ-1:0] y);
    logic [ADDRSZ-1:0] yw;
    yw = ADDRSZ'(y);
    return (yw << 7) + (yw << 5) + ADDRSZ'(x);
  endfunction

  function automatic logic is_last(input logic [XSZ-1:0] x,
                                   input logic [YSZ-1:0] y);
    return (x == X_LAST) && (y == Y_LAST);
  endfunction

  // Raster successor packed as {y, x}
  function automatic logic [XSZ+YSZ-1:0] succ(input logic [XSZ-1:0] x,
                                              input logic [YSZ-1:0] y);
    if (x == X_LAST) begin
      if (y == Y_LAST) return '0;
      return {y + YSZ'(1), {XSZ{1'b0}}};
    end
    return {y, x + XSZ'(1)};
  endfunction

  state_t            state_q, state_d;
  logic [XSZ-1:0]    cx_q, cx_d;
  logic [YSZ-1:0]    cy_q, cy_d;
  logic              last_iss_q, last_iss_d;
  logic              vld_p0_q, vld_p0_d;
  logic              vld_p1_q, vld_p1_d;
  logic [XSZ-1:0]    x_p0_q, x_p0_d, x_p1_q, x_p1_d;
  logic [YSZ-1:0]    y_p0_q, y_p0_d, y_p1_q, y_p1_d;
  logic [ADDRSZ-1:0] addr_q, addr_d;
  logic [XSZ-1:0]    star_x_q, star_x_d;
  logic [YSZ-1:0]    star_y_q, star_y_d;
  logic              found_q, found_d;
  logic              done_q, done_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cx_q       <= '0;
      cy_q       <= '0;
      last_iss_q <= 1'b0;
      vld_p0_q   <= 1'b0;
      vld_p1_q   <= 1'b0;
      addr_q     <= '0;
      star_x_q   <= '0;
      star_y_q   <= '0;
      found_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      last_iss_q <= last_iss_d;
      vld_p0_q   <= vld_p0_d;
      vld_p1_q   <= vld_p1_d;
      addr_q     <= addr_d;
      star_x_q   <= star_x_d;
      star_y_q   <= star_y_d;
      found_q    <= found_d;
      done_q     <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    x_p0_q <= x_p0_d;
    y_p0_q <= y_p0_d;
    x_p1_q <= x_p1_d;
    y_p1_q <= y_p1_d;
  end

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    last_iss_d = last_iss_q;
    vld_p0_d   = vld_p0_q;
    vld_p1_d   = vld_p1_q;
    x_p0_d     = x_p0_q;
    y_p0_d     = y_p0_q;
    x_p1_d     = x_p1_q;
    y_p1_d     = y_p1_q;
    addr_d     = addr_q;
    star_x_d   = star_x_q;
    star_y_d   = star_y_q;
    found_d    = found_q;
    done_d     = done_q;

    case (state_q)
      IDLE: begin
        cx_d       = '0;
        cy_d       = '0;
        last_iss_d = 1'b0;
        vld_p0_d   = 1'b0;
        vld_p1_d   = 1'b0;
        if (sif.start) state_d = SCAN;
      end

      SCAN: begin
        // p0 -> p1: coordinate moves with its read into the data cycle
        x_p1_d   = x_p0_q;
        y_p1_d   = y_p0_q;
        vld_p1_d = vld_p0_q;
        vld_p0_d = 1'b0;
        // p0: issue the counter pixel until the last one has gone out
        if (!last_iss_q) begin
          addr_d       = pix_addr(cx_q, cy_q);
          x_p0_d       = cx_q;
          y_p0_d       = cy_q;
          vld_p0_d     = 1'b1;
          {cy_d, cx_d} = succ(cx_q, cy_q);
          last_iss_d   = is_last(cx_q, cy_q);
        end
        // p1 compare: on a hit the read in flight is dropped and the counter
        // rewinds to the pixel right after the hit so nothing is skipped
        if (vld_p1_q && (sif.mem_data == STAR_COL)) begin
          star_x_d     = x_p1_q;
          star_y_d     = y_p1_q;
          found_d      = 1'b1;
          state_d      = FOUND;
          {cy_d, cx_d} = succ(x_p1_q, y_p1_q);
          last_iss_d   = 1'b0;
          vld_p0_d     = 1'b0;
          vld_p1_d     = 1'b0;
          addr_d       = addr_q;
        end else if (vld_p1_q && is_last(x_p1_q, y_p1_q)) begin
          done_d   = 1'b1;
          state_d  = DONE;
          vld_p0_d = 1'b0;
          vld_p1_d = 1'b0;
        end
      end

      FOUND: begin
        if (sif.next_star) begin
          found_d = 1'b0;
          if (is_last(star_x_q, star_y_q)) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SCAN;
          end
        end
      end

      DONE: begin
        // start must fall before another scan can begin
        if (!sif.start) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign sif.mem_addr   = addr_q;
  assign sif.star_x     = star_x_q;
  assign sif.star_y     = star_y_q;
  assign sif.star_found = found_q;
  assign sif.scan_done  = done_q;

endmodule
